// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE / GRANT)
//   BURST_W     : width of the per-grant burst counter
//   id_w()      : owner index width, max(1, clog2(n))
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int BURST_W = 4;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req        in  NUM_REQ  request vector
//   last_owner in  ID_W     previous owner; scan starts one above it
//   pick_valid out 1        any request present
//   pick_id    out ID_W     first requester at or after last_owner+1 (mod NUM_REQ)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_owner,
  output logic               pick_valid,
  output logic [ID_W-1:0]    pick_id
);

  // Distance of requester j from the scan start; the previous owner ends
  // up at NUM_REQ-1, i.e. lowest priority but still eligible.
  function automatic int rr_dist(input int j, input int lo);
    return (j - lo - 1 + 2 * NUM_REQ) % NUM_REQ;
  endfunction

  int best_d;

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    best_d     = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j] && (rr_dist(j, int'(last_owner)) < best_d)) begin
        best_d     = rr_dist(j, int'(last_owner));
        pick_valid = 1'b1;
        pick_id    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// sync_fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port
// among NUM_REQ valid/ready producers, with a per-grant burst limit.
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_valid_i    per-producer word available
//   req_data_i     producer k data at [k*DATA_W +: DATA_W]
//   req_ready_o    per-producer accept (one-hot or zero)
//   fifo_full_i    FIFO full; blocks transfers in the same cycle
//   fifo_wr_en_o   FIFO write enable (= transfer)
//   fifo_data_o    owner's data while granted, else 0
//   grant_valid_o  a producer owns the port
//   grant_id_o     owner index while granted, else 0
module sync_fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 16,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = id_w(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      fifo_full_i,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_data_o,
  output logic                      grant_valid_o,
  output logic [ID_W-1:0]           grant_id_o
);

  arb_state_t               state, state_nx;
  logic [ID_W-1:0]          owner, owner_nx;
  logic [ID_W-1:0]          last_owner, last_owner_nx;
  logic [BURST_W-1:0]       burst_cnt, burst_cnt_nx;

  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_a;
  logic                     granted, owner_vld, xfer, burst_last, rel;
  logic [ID_W-1:0]          pick_base, pick_id;
  logic                     pick_valid;

  assign req_data_a = req_data_i;

  assign granted    = (state == GRANT);
  assign owner_vld  = req_valid_i[owner];
  // Reset gates the transfer so an aborted burst never writes.
  assign xfer       = granted && owner_vld && !fifo_full_i && !rst_i;
  assign burst_last = (burst_cnt == BURST_W'(MAX_BURST - 1));
  // Full alone never releases: it blocks xfer but leaves owner_vld high.
  assign rel        = granted && ((xfer && burst_last) || !owner_vld);

  // On release the departing owner becomes the scan base in the same
  // cycle, so the handover re-arbitrates without a bubble.
  assign pick_base  = rel ? owner : last_owner;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_valid_i),
    .last_owner (pick_base),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    burst_cnt_nx  = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nx     = pick_id;
          burst_cnt_nx = '0;
          state_nx     = GRANT;
        end
      end
      GRANT: begin
        if (xfer) burst_cnt_nx = burst_cnt + 1'b1;
        if (rel) begin
          last_owner_nx = owner;
          if (pick_valid) begin
            owner_nx     = pick_id;
            burst_cnt_nx = '0;
          end else begin
            state_nx     = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= ID_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      burst_cnt  <= burst_cnt_nx;
    end
  end

  always_comb begin
    req_ready_o = '0;
    fifo_data_o = '0;
    if (granted && !rst_i) begin
      req_ready_o[owner] = owner_vld && !fifo_full_i;
      fifo_data_o        = req_data_a[owner];
    end
  end

  assign fifo_wr_en_o  = xfer;
  assign grant_valid_o = granted && !rst_i;
  assign grant_id_o    = (granted && !rst_i) ? owner : '0;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
module tb_sync_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_valid_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            fifo_full_i = 1'b0;
  logic            fifo_wr_en_o;
  logic [DW-1:0]   fifo_data_o;
  logic            grant_valid_o;
  logic [1:0]      grant_id_o;

  always #5 clk_i = ~clk_i;

  sync_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .fifo_full_i   (fifo_full_i),
    .fifo_wr_en_o  (fifo_wr_en_o),
    .fifo_data_o   (fifo_data_o),
    .grant_valid_o (grant_valid_o),
    .grant_id_o    (grant_id_o)
  );

  int total = 0;
  int bad   = 0;

  // Producer model: rem words left, seq next word number; word = {id, seq}.
  int            rem[N];
  int            seq[N];
  int            exp_seq[N];
  logic [N-1:0]  en;
  logic          full_nx, rst_nx;
  logic [N-1:0]  hs;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  task automatic drive();
    rst_i       = rst_nx;
    fifo_full_i = full_nx;
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]          = (rem[k] > 0) && en[k];
      req_data_i[k*DW +: DW]  = {4'(k), 12'(seq[k])};
    end
  endtask

  // Advance one cycle: retire last cycle's handshakes, drive, then stop at
  // the negedge where the new cycle's outputs are settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < N; k++)
      if (hs[k]) begin
        seq[k]++;
        rem[k]--;
      end
    drive();
    @(negedge clk_i);
    hs = req_ready_o & req_valid_i;
  endtask

  task automatic push_exp(input int p, input int n);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back({4'(p), 12'(exp_seq[p])});
      exp_seq[p]++;
    end
  endtask

  function automatic int rem_sum();
    int s = 0;
    for (int k = 0; k < N; k++) s += rem[k];
    return s;
  endfunction

  task automatic do_reset();
    en      = '1;
    full_nx = 1'b0;
    rst_nx  = 1'b1;
    tick();
    tick();
    rst_nx  = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rem_sum() != 0) && n < 80) begin
      tick();
      n++;
    end
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0 || rem_sum() != 0 || grant_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d rem=%0d gv=%b want 0 0 0",
               name, exp_q.size(), rem_sum(), grant_valid_o);
    end
  endtask

  // Scoreboard: every FIFO write must be the next expected word.
  always @(negedge clk_i) begin
    total++;
    if (!$onehot0(req_ready_o)) begin
      bad++;
      $display("FAIL ready_onehot got=%b want=onehot0", req_ready_o);
    end
    if (fifo_wr_en_o === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%h want=no write", fifo_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_data_o !== mon_exp) begin
          bad++;
          $display("FAIL write_data got=%h want=%h", fifo_data_o, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_nx = 1'b1;
    rem[1] = 1;
    tick();
    tick();
    total++;
    if ({req_ready_o, fifo_wr_en_o, fifo_data_o, grant_valid_o, grant_id_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {req_ready_o, fifo_wr_en_o, fifo_data_o, grant_valid_o, grant_id_o});
    end
    rem[1] = 0;
    rst_nx = 1'b0;
    tick();
    total++;
    if (grant_valid_o !== 1'b0 || dut.last_owner !== 2'd3 || dut.burst_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_state got gv=%b lo=%0d bc=%0d want 0 3 0",
               grant_valid_o, dut.last_owner, dut.burst_cnt);
    end
  endtask

  task automatic test_sole();
    do_reset();
    push_exp(0, 6);
    rem[0] = 6;
    tick();
    total++;
    if (grant_valid_o !== 1'b0 || fifo_wr_en_o !== 1'b0) begin
      bad++;
      $display("FAIL sole_c0 got gv=%b we=%b want 0 0", grant_valid_o, fifo_wr_en_o);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      total++;
      if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd0 || fifo_wr_en_o !== 1'b1) begin
        bad++;
        $display("FAIL sole_c%0d got gv=%b id=%0d we=%b want 1 0 1",
                 c, grant_valid_o, grant_id_o, fifo_wr_en_o);
      end
    end
    tick();
    total++;
    if (grant_valid_o !== 1'b1 || fifo_wr_en_o !== 1'b0) begin
      bad++;
      $display("FAIL sole_c7 got gv=%b we=%b want 1 0", grant_valid_o, fifo_wr_en_o);
    end
    tick();
    total++;
    if (grant_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL sole_idle got gv=%b want 0", grant_valid_o);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int p = 0; p < N; p++) push_exp(p, 4);
    for (int p = 0; p < N; p++) push_exp(p, 1);
    for (int p = 0; p < N; p++) rem[p] = 5;
    tick();
    for (int c = 1; c <= 17; c++) begin
      tick();
      total++;
      if (fifo_wr_en_o !== 1'b1 || grant_id_o !== 2'(((c - 1) / 4) % 4)) begin
        bad++;
        $display("FAIL all4_c%0d got we=%b id=%0d want 1 %0d",
                 c, fifo_wr_en_o, grant_id_o, ((c - 1) / 4) % 4);
      end
    end
    drain("all4");
  endtask

  task automatic test_full_stall();
    do_reset();
    push_exp(1, 4);
    push_exp(2, 2);
    rem[1] = 4;
    rem[2] = 2;
    tick();
    for (int c = 1; c <= 2; c++) begin
      tick();
      total++;
      if (fifo_wr_en_o !== 1'b1 || grant_id_o !== 2'd1) begin
        bad++;
        $display("FAIL full_pre_c%0d got we=%b id=%0d want 1 1", c, fifo_wr_en_o, grant_id_o);
      end
    end
    full_nx = 1'b1;
    for (int c = 3; c <= 5; c++) begin
      tick();
      total++;
      if (req_ready_o !== 4'b0 || fifo_wr_en_o !== 1'b0 ||
          grant_valid_o !== 1'b1 || grant_id_o !== 2'd1) begin
        bad++;
        $display("FAIL full_hold_c%0d got rdy=%b we=%b gv=%b id=%0d want 0 0 1 1",
                 c, req_ready_o, fifo_wr_en_o, grant_valid_o, grant_id_o);
      end
    end
    full_nx = 1'b0;
    for (int c = 6; c <= 7; c++) begin
      tick();
      total++;
      if (fifo_wr_en_o !== 1'b1 || grant_id_o !== 2'd1) begin
        bad++;
        $display("FAIL full_post_c%0d got we=%b id=%0d want 1 1", c, fifo_wr_en_o, grant_id_o);
      end
    end
    tick();
    total++;
    if (fifo_wr_en_o !== 1'b1 || grant_id_o !== 2'd2) begin
      bad++;
      $display("FAIL full_handover got we=%b id=%0d want 1 2", fifo_wr_en_o, grant_id_o);
    end
    drain("full");
  endtask

  task automatic test_owner_drop();
    do_reset();
    push_exp(0, 2);
    push_exp(2, 2);
    push_exp(0, 2);
    rem[0] = 4;
    rem[2] = 2;
    tick();
    tick();
    tick();
    en[0] = 1'b0;
    tick();
    total++;
    if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd0 || fifo_wr_en_o !== 1'b0) begin
      bad++;
      $display("FAIL drop_gap got gv=%b id=%0d we=%b want 1 0 0",
               grant_valid_o, grant_id_o, fifo_wr_en_o);
    end
    en[0] = 1'b1;
    tick();
    total++;
    if (grant_id_o !== 2'd2 || fifo_wr_en_o !== 1'b1 || dut.last_owner !== 2'd0) begin
      bad++;
      $display("FAIL drop_new_owner got id=%0d we=%b lo=%0d want 2 1 0",
               grant_id_o, fifo_wr_en_o, dut.last_owner);
    end
    drain("drop");
  endtask

  task automatic test_pick_idle();
    do_reset();
    push_exp(2, 1);
    rem[2] = 1;
    drain("pick_setup");
    push_exp(3, 2);
    push_exp(1, 2);
    rem[1] = 2;
    rem[3] = 2;
    tick();
    total++;
    if (grant_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL pick_idle_c0 got gv=%b want 0", grant_valid_o);
    end
    tick();
    total++;
    if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd3) begin
      bad++;
      $display("FAIL pick_first got gv=%b id=%0d want 1 3", grant_valid_o, grant_id_o);
    end
    drain("pick");
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_exp(3, 2);
    rem[3] = 4;
    tick();
    tick();
    total++;
    if (grant_id_o !== 2'd3 || fifo_wr_en_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_burst got id=%0d we=%b want 3 1", grant_id_o, fifo_wr_en_o);
    end
    tick();
    rst_nx = 1'b1;
    tick();
    total++;
    if ({req_ready_o, fifo_wr_en_o, fifo_data_o, grant_valid_o, grant_id_o} !== '0) begin
      bad++;
      $display("FAIL rmid_outputs got=%h want=0",
               {req_ready_o, fifo_wr_en_o, fifo_data_o, grant_valid_o, grant_id_o});
    end
    rst_nx = 1'b0;
    push_exp(0, 2);
    push_exp(3, 2);
    rem[0] = 2;
    tick();
    total++;
    if (grant_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rmid_idle got gv=%b want 0", grant_valid_o);
    end
    tick();
    total++;
    if (grant_valid_o !== 1'b1 || grant_id_o !== 2'd0) begin
      bad++;
      $display("FAIL rmid_prio got gv=%b id=%0d want 1 0", grant_valid_o, grant_id_o);
    end
    drain("rmid");
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rem[k]     = 0;
      seq[k]     = 0;
      exp_seq[k] = 0;
    end
    en      = '1;
    full_nx = 1'b0;
    rst_nx  = 1'b1;
    hs      = '0;
    test_reset();
    test_sole();
    test_all_four();
    test_full_stall();
    test_owner_drop();
    test_pick_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
